bitlet_pe_scheduler: RTL and testbench
======================================

Name: bitlet_pe_scheduler

Overview:
Job-level sequencer for one Bitlet PE. For each output of a job it does four things in order:
- requests a weight set;
- pulses the PE flush;
- streams N_total/N_input activation beats into the PE;
- captures the PE result into a one-entry valid/ready output register.

It sits between the activation/weight buffers and the PE, and owns all of the PE's control strobes.

Parameters:
N_total, 64, inputs per dot product; must be a multiple of N_input
N_input, 16, activations per beat
WID_BIN, 16, activation/result word width (equals `Wid_bin)
MAX_JOB, 1024, maximum outputs per job
TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset: one clock; reset is synchronous and active-low
start  in  1  job start pulse; ignored while busy
job_len  in  $clog2(MAX_JOB)  number of outputs minus 1; sampled on an accepted start
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse when the last result is accepted downstream
wgt_req  out  1  weight set request; held until wgt_ack
wgt_ack  in  1  weights are now stable on the PE weight ports
wgt_hold  out  1  weight buffer must keep its outputs stable while this is high
act_valid  in  1  activation beat valid
act_ready  out  1  activation beat accept
act_data  in  N_input*WID_BIN  activation beat
pe_flush  out  1  PE flush, one cycle
pe_Abin_vld  out  1  PE activation strobe, one cycle per beat
pe_Abin_vec  out  N_input*WID_BIN  PE activation vector, registered
pe_res_vld  in  1  PE result strobe
pe_res  in  WID_BIN  PE result
res_valid  out  1  output valid
res_ready  in  1  output accept
res_data  out  WID_BIN  output result
res_last  out  1  marks the last result of a job
err  out  1  sticky protocol error; cleared by the next accepted start

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, all counters are 0. A reset asserted mid-job aborts the job with no done pulse and discards any pending result.
- Beat count B = N_total/N_input. The output counter oc runs from 0 to job_len.
- IDLE: start → latch job_len, clear oc and err, set busy, go to WREQ.
- WREQ:
  - wgt_req is high.
  - On wgt_ack, set wgt_hold and wait for the output register to be free: res_valid==0, or res_valid&&res_ready in the same cycle.
  - Once free, go to FLUSH. If wgt_ack arrives while the register is still full, wgt_hold stays high and the FSM stays in WREQ with wgt_req low.
- FLUSH: pe_flush=1 for exactly one cycle, then go to FEED with the beat counter at 0.
- FEED:
  - act_ready=1.
  - Each act_valid&&act_ready handshake registers act_data into pe_Abin_vec and pulses pe_Abin_vld the next cycle.
  - Act_valid gaps are allowed.
  - After beat B-1 is accepted, act_ready drops the same cycle and the FSM goes to WAIT. There is never more than one beat per cycle.
- WAIT:
  - On pe_res_vld: res_data<=pe_res, res_valid<=1, res_last<=(oc==job_len), wgt_hold<=0.
  - If oc==job_len, go to DRAIN; otherwise oc++ and go to WREQ.
- DRAIN: when res_valid&&res_ready, assert done for one cycle, clear busy, go to IDLE.
- Output register:
  - res_valid clears on res_ready when no new capture occurs in the same cycle.
  - A capture can never collide with a full register; this is guaranteed by the WREQ gating.
  - res_data is stable while res_valid&&!res_ready.
- Protocol errors: pe_res_vld outside WAIT, or wgt_ack outside WREQ, sets err. The event is otherwise ignored and the FSM is unaffected.
- start while busy: ignored, no error.
- Latency:
  - Accepted start → wgt_req: 1 cycle.
  - Last beat accepted → pe_Abin_vld: 1 cycle.
  - pe_res_vld → res_valid: 1 cycle.

Optional Feature:
Macro BITLET_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and in WREQ while wgt_req is high, and clears on each state entry.
  - When the count reaches TIMEOUT, set err, drop wgt_req and wgt_hold, clear busy, pulse done, and return to IDLE.
  - A result already held in the output register is still delivered.
- Undefined: there is no counter, and WAIT/WREQ wait indefinitely.

Test Plan:
- Basic single output (job_len=0, B=4, act_valid and res_ready held high, wgt_ack 2 cycles after wgt_req):
  - expected order is wgt_req, wgt_ack, pe_flush×1, pe_Abin_vld×4 with vectors matching act_data in order;
  - pe_res=16'h1234 → res_data=16'h1234 with res_last=1, then done 1 cycle after the handshake, then busy=0.
- Three outputs with act_valid toggling every other cycle:
  - exactly 4 beats per output and 3 pe_flush pulses;
  - res_last high only on the 3rd result;
  - oc reaches 2.
- Backpressure: res_ready=0 for 20 cycles after the first result of a 2-output job:
  - the FSM stalls in WREQ after wgt_ack, with no pe_flush;
  - result 1 is held stable;
  - releasing res_ready resumes the job and no result is lost.
- Protocol errors and ignored start:
  - stray pe_res_vld in FEED → err=1, beat count unaffected;
  - start while busy → ignored;
  - next accepted start → err=0.
- Reset mid-job: pull rst_n low during FEED beat 2 → next cycle all outputs are 0 and the FSM is IDLE; a new job then completes normally.
- With BITLET_SCHED_TIMEOUT_EN and TIMEOUT=255: no pe_res_vld in WAIT → err=1, done pulse, busy=0 after the timeout.

Source files
------------

// File: rtl/bitlet_pe_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bitlet_pe_scheduler                                              |
// | Brief   : Job-level sequencer for one Bitlet PE. For each output it        |
// |           requests weights, flushes the PE, streams activation beats and   |
// |           captures the result into a one-entry valid/ready register.       |
// |           Optional watchdog: define BITLET_SCHED_TIMEOUT_EN.               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module bitlet_pe_scheduler #(
    parameter int N_TOTAL = 64,
    parameter int N_INPUT = 16,
    parameter int WID_BIN = 16,
    parameter int MAX_JOB = 1024,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [$clog2(MAX_JOB)-1:0]    job_len,
    output logic                          busy,
    output logic                          done,
    output logic                          wgt_req,
    input  logic                          wgt_ack,
    output logic                          wgt_hold,
    input  logic                          act_valid,
    output logic                          act_ready,
    input  logic [N_INPUT*WID_BIN-1:0]    act_data,
    output logic                          pe_flush,
    output logic                          pe_Abin_vld,
    output logic [N_INPUT*WID_BIN-1:0]    pe_Abin_vec,
    input  logic                          pe_res_vld,
    input  logic [WID_BIN-1:0]            pe_res,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [WID_BIN-1:0]            res_data,
    output logic                          res_last,
    output logic                          err
);

    localparam int c_beats     = N_TOTAL / N_INPUT;
    localparam int c_beat_w    = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int c_job_w     = $clog2(MAX_JOB);
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_beats - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WREQ  = 3'd1,
        S_FLUSH = 3'd2,
        S_FEED  = 3'd3,
        S_WAIT  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [c_job_w-1:0]           r_job_len;
    logic [c_job_w-1:0]           r_oc;
    logic [c_beat_w-1:0]          r_beat;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_err;
    logic                         r_wgt_hold;
    logic                         r_abin_vld;
    logic [N_INPUT*WID_BIN-1:0]   r_abin_vec;
    logic                         r_res_valid;
    logic [WID_BIN-1:0]           r_res_data;
    logic                         r_res_last;

    logic w_start_acc;
    logic w_ack_take;
    logic w_reg_free;
    logic w_beat_acc;
    logic w_capture;
    logic w_drain_done;
    logic w_proto_err;
    logic w_tmo_hit;

`ifdef BITLET_SCHED_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TIMEOUT + 1);

    logic [c_tmo_w-1:0] r_tmo;
    logic               w_tmo_run;

    // Runs while the PE or the weight buffer owes us a response.
    assign w_tmo_run = (r_state == S_WAIT) || ((r_state == S_WREQ) && !r_wgt_hold);
    assign w_tmo_hit = w_tmo_run && (r_tmo == c_tmo_w'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (!w_tmo_run || (w_state_nxt != r_state)) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end
`else
    assign w_tmo_hit = (TIMEOUT < 0);
`endif

    assign w_proto_err = (pe_res_vld && (r_state != S_WAIT)) ||
                         (wgt_ack && (r_state != S_WREQ));

    always_comb begin
        w_state_nxt  = r_state;
        w_start_acc  = 1'b0;
        w_ack_take   = 1'b0;
        w_beat_acc   = 1'b0;
        w_capture    = 1'b0;
        w_drain_done = 1'b0;
        w_reg_free   = !r_res_valid || res_ready;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_WREQ;
                end
            end
            S_WREQ: begin
                w_ack_take = wgt_ack && !r_wgt_hold;
                // Flushing is held off until the output register can take the next capture.
                if (w_tmo_hit) begin
                    w_state_nxt = S_IDLE;
                end else if ((r_wgt_hold || wgt_ack) && w_reg_free) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_FEED;
            end
            S_FEED: begin
                w_beat_acc = act_valid;
                if (act_valid && (r_beat == c_last_beat)) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_tmo_hit) begin
                    w_state_nxt = S_IDLE;
                end else if (pe_res_vld) begin
                    w_capture   = 1'b1;
                    w_state_nxt = (r_oc == r_job_len) ? S_DRAIN : S_WREQ;
                end
            end
            S_DRAIN: begin
                if (r_res_valid && res_ready) begin
                    w_drain_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_job_len   <= '0;
            r_oc        <= '0;
            r_beat      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_wgt_hold  <= 1'b0;
            r_abin_vld  <= 1'b0;
            r_abin_vec  <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_drain_done || w_tmo_hit;

            if (w_start_acc) begin
                r_job_len <= job_len;
                r_oc      <= '0;
                r_busy    <= 1'b1;
            end else if (w_drain_done || w_tmo_hit) begin
                r_busy <= 1'b0;
            end

            // A same-cycle violation wins over the clear so it is never lost.
            if (w_proto_err || w_tmo_hit) begin
                r_err <= 1'b1;
            end else if (w_start_acc) begin
                r_err <= 1'b0;
            end

            if (w_ack_take) begin
                r_wgt_hold <= 1'b1;
            end else if (w_capture || w_tmo_hit) begin
                r_wgt_hold <= 1'b0;
            end

            if (r_state == S_FLUSH) begin
                r_beat <= '0;
            end else if (w_beat_acc) begin
                r_beat <= r_beat + 1'b1;
            end

            r_abin_vld <= w_beat_acc;
            if (w_beat_acc) begin
                r_abin_vec <= act_data;
            end

            if (w_capture) begin
                r_res_data  <= pe_res;
                r_res_valid <= 1'b1;
                r_res_last  <= (r_oc == r_job_len);
                if (r_oc != r_job_len) begin
                    r_oc <= r_oc + 1'b1;
                end
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
                r_res_last  <= 1'b0;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign wgt_req     = (r_state == S_WREQ) && !r_wgt_hold;
    assign wgt_hold    = r_wgt_hold;
    assign act_ready   = (r_state == S_FEED);
    assign pe_flush    = (r_state == S_FLUSH);
    assign pe_Abin_vld = r_abin_vld;
    assign pe_Abin_vec = r_abin_vec;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_last    = r_res_last;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bitlet_pe_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bitlet_pe_scheduler                                           |
// | Brief   : Randomized scenario bench for bitlet_pe_scheduler with a         |
// |           scoreboard of accepted beats and returned results.               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_bitlet_pe_scheduler;

    localparam int N_TOTAL = 64;
    localparam int N_INPUT = 16;
    localparam int WID_BIN = 16;
    localparam int MAX_JOB = 1024;
    localparam int TIMEOUT = 255;
    localparam int B       = N_TOTAL / N_INPUT;
    localparam int VW      = N_INPUT * WID_BIN;
    localparam int JW      = $clog2(MAX_JOB);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [JW-1:0]      job_len = '0;
    logic               busy, done, wgt_req, wgt_hold, act_ready, pe_flush, pe_Abin_vld;
    logic               res_valid, res_last, err;
    logic               wgt_ack = 1'b0;
    logic               act_valid = 1'b0;
    logic [VW-1:0]      act_data = '0;
    logic [VW-1:0]      pe_Abin_vec;
    logic               pe_res_vld = 1'b0;
    logic [WID_BIN-1:0] pe_res = '0;
    logic               res_ready = 1'b1;
    logic [WID_BIN-1:0] res_data;

    always #5 clk = ~clk;

    bitlet_pe_scheduler #(
        .N_TOTAL(N_TOTAL), .N_INPUT(N_INPUT), .WID_BIN(WID_BIN),
        .MAX_JOB(MAX_JOB), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .job_len(job_len),
        .busy(busy), .done(done), .wgt_req(wgt_req), .wgt_ack(wgt_ack),
        .wgt_hold(wgt_hold), .act_valid(act_valid), .act_ready(act_ready),
        .act_data(act_data), .pe_flush(pe_flush), .pe_Abin_vld(pe_Abin_vld),
        .pe_Abin_vec(pe_Abin_vec), .pe_res_vld(pe_res_vld), .pe_res(pe_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: beats/results the environment handed over vs. what came out.
    logic [VW-1:0]      exp_vec[$];
    logic [VW-1:0]      obs_vec[$];
    logic [WID_BIN-1:0] exp_res[$];
    logic [WID_BIN-1:0] obs_res[$];
    bit                 obs_last[$];
    int n_flush, n_done, n_unstable, n_flush_full, n_req_held;
    int done_lat, ack_cyc, flush_cyc, vld_cyc;
    bit first_busy, first_req, err_at_start, err_at_end, timed_out, done_busy;

    task automatic rand_act();
        for (int k = 0; k < VW / 32; k++) act_data[k*32 +: 32] = $urandom();
    endtask

    task automatic drive_job(input int len, input bit gap, input int bp, input int ack_dly,
                             input bit rnd_ready, input bit stray, input bit restart,
                             input bit use_fixed, input logic [WID_BIN-1:0] fixed_res);
        int cyc = 0, req_cnt = 0, beat_mod = 0, res_pend = 0, bp_left = bp, last_hs = -10;
        bit held = 0, stray_done = 0, restart_done = 0, tog = 0;
        logic [WID_BIN-1:0] held_data = '0;
        exp_vec.delete(); obs_vec.delete(); exp_res.delete(); obs_res.delete(); obs_last.delete();
        n_flush = 0; n_done = 0; n_unstable = 0; n_flush_full = 0; n_req_held = 0;
        done_lat = -1; ack_cyc = -1; flush_cyc = -1; vld_cyc = -1; timed_out = 0; done_busy = 1;
        start = 1'b1; job_len = JW'(len);
        @(posedge clk); #1;
        start = 1'b0;
        first_busy = busy; first_req = wgt_req; err_at_start = err;
        forever begin
            if (pe_flush) begin
                n_flush++;
                if (flush_cyc < 0) flush_cyc = cyc;
                if (res_valid) n_flush_full++;
            end
            if (wgt_req && wgt_hold) n_req_held++;
            if (pe_Abin_vld) begin
                obs_vec.push_back(pe_Abin_vec);
                if (vld_cyc < 0) vld_cyc = cyc;
                beat_mod++;
                if (beat_mod == B) begin
                    beat_mod = 0;
                    res_pend = $urandom_range(1, 3);
                end
            end
            if (held && (!res_valid || res_data !== held_data)) n_unstable++;
            if (done) begin
                n_done++; done_busy = busy; done_lat = cyc - last_hs;
                break;
            end
            if (cyc > 3000) begin
                timed_out = 1;
                break;
            end
            req_cnt = wgt_req ? req_cnt + 1 : 0;
            wgt_ack = (req_cnt == ack_dly + 1);
            if (wgt_ack && ack_cyc < 0) ack_cyc = cyc;
            tog = !tog;
            act_valid = gap ? tog : 1'b1;
            rand_act();
            pe_res_vld = 1'b0;
            pe_res = WID_BIN'($urandom());
            if (res_pend > 0) begin
                res_pend--;
                if (res_pend == 0) begin
                    pe_res_vld = 1'b1;
                    if (use_fixed) pe_res = fixed_res;
                    exp_res.push_back(pe_res);
                end
            end else if (stray && !stray_done && act_ready && obs_vec.size() > 0) begin
                pe_res_vld = 1'b1;
                stray_done = 1;
            end
            start = 1'b0;
            if (restart && !restart_done && act_ready) begin
                start = 1'b1; job_len = JW'(len + 5); restart_done = 1;
            end
            if (bp_left > 0 && res_valid) begin
                res_ready = 1'b0; bp_left--;
            end else begin
                res_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (act_valid && act_ready) exp_vec.push_back(act_data);
            if (res_valid && res_ready) begin
                obs_res.push_back(res_data); obs_last.push_back(res_last); last_hs = cyc;
            end
            held = res_valid && !res_ready;
            held_data = res_data;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; wgt_ack = 1'b0; act_valid = 1'b0; pe_res_vld = 1'b0; res_ready = 1'b1;
        err_at_end = err;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, done, wgt_req, wgt_hold, act_ready, pe_flush, pe_Abin_vld, res_valid, res_last, err} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0", {busy, done, wgt_req, wgt_hold, act_ready, pe_flush, pe_Abin_vld, res_valid, res_last, err});
        end
        n_checks++;
        if (pe_Abin_vec !== '0 || res_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got vec %0h res %0h expected 0", pe_Abin_vec, res_data);
        end
    endtask

    task automatic test_basic();
        drive_job(0, 0, 0, 2, 0, 0, 0, 1, 16'h1234);
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL basic_timeout: job never finished"); end
        n_checks++;
        if (first_busy !== 1'b1 || first_req !== 1'b1) begin
            n_fail++; $display("FAIL basic_start_latency: busy %b req %b expected 1 1", first_busy, first_req);
        end
        n_checks++;
        if (ack_cyc != 2 || flush_cyc != ack_cyc + 1 || vld_cyc != flush_cyc + 2) begin
            n_fail++; $display("FAIL basic_order: ack %0d flush %0d vld %0d expected 2 3 5", ack_cyc, flush_cyc, vld_cyc);
        end
        n_checks++;
        if (n_flush != 1 || obs_vec.size() != B) begin
            n_fail++; $display("FAIL basic_counts: flush %0d beats %0d expected 1 %0d", n_flush, obs_vec.size(), B);
        end
        for (int i = 0; i < exp_vec.size(); i++) begin
            n_checks++;
            if (i >= obs_vec.size() || obs_vec[i] !== exp_vec[i]) begin
                n_fail++; $display("FAIL basic_vec%0d: got %0h expected %0h", i, (i < obs_vec.size()) ? obs_vec[i] : '0, exp_vec[i]);
            end
        end
        n_checks++;
        if (obs_res.size() != 1 || obs_res[0] !== 16'h1234 || obs_last[0] !== 1'b1) begin
            n_fail++; $display("FAIL basic_result: got n=%0d data %0h last %b expected 1 1234 1",
                                obs_res.size(), (obs_res.size() > 0) ? obs_res[0] : 16'h0, (obs_last.size() > 0) ? obs_last[0] : 1'b0);
        end
        n_checks++;
        if (n_done != 1 || done_lat != 1 || done_busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_done: n %0d latency %0d busy %b expected 1 1 0", n_done, done_lat, done_busy);
        end
    endtask

    task automatic test_multi();
        drive_job(2, 1, 0, 1, 0, 0, 0, 0, '0);
        n_checks++;
        if (timed_out || n_flush != 3 || obs_vec.size() != 3 * B) begin
            n_fail++; $display("FAIL multi_counts: flush %0d beats %0d expected 3 %0d", n_flush, obs_vec.size(), 3 * B);
        end
        for (int i = 0; i < exp_vec.size(); i++) begin
            n_checks++;
            if (i >= obs_vec.size() || obs_vec[i] !== exp_vec[i]) begin
                n_fail++; $display("FAIL multi_vec%0d: got %0h expected %0h", i, (i < obs_vec.size()) ? obs_vec[i] : '0, exp_vec[i]);
            end
        end
        n_checks++;
        if (obs_res.size() != 3) begin n_fail++; $display("FAIL multi_nres: got %0d expected 3", obs_res.size()); end
        for (int i = 0; i < obs_res.size() && i < exp_res.size(); i++) begin
            n_checks++;
            if (obs_res[i] !== exp_res[i] || obs_last[i] !== (i == 2)) begin
                n_fail++; $display("FAIL multi_res%0d: got %0h last %b expected %0h last %b", i, obs_res[i], obs_last[i], exp_res[i], (i == 2));
            end
        end
    endtask

    task automatic test_backpressure();
        drive_job(1, 0, 20, 1, 0, 0, 0, 0, '0);
        n_checks++;
        if (timed_out || n_done != 1) begin n_fail++; $display("FAIL bp_done: got %0d expected 1", n_done); end
        n_checks++;
        if (n_unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", n_unstable); end
        n_checks++;
        if (n_flush_full != 0 || n_req_held != 0 || n_flush != 2) begin
            n_fail++; $display("FAIL bp_stall: flush_full %0d req_held %0d flush %0d expected 0 0 2", n_flush_full, n_req_held, n_flush);
        end
        n_checks++;
        if (obs_res.size() != 2) begin n_fail++; $display("FAIL bp_nres: got %0d expected 2", obs_res.size()); end
        for (int i = 0; i < obs_res.size() && i < exp_res.size(); i++) begin
            n_checks++;
            if (obs_res[i] !== exp_res[i]) begin
                n_fail++; $display("FAIL bp_res%0d: got %0h expected %0h", i, obs_res[i], exp_res[i]);
            end
        end
    endtask

    task automatic test_protocol();
        drive_job(1, 0, 0, 0, 0, 1, 1, 0, '0);
        n_checks++;
        if (err_at_end !== 1'b1) begin n_fail++; $display("FAIL proto_err_set: got %b expected 1", err_at_end); end
        n_checks++;
        if (timed_out || obs_vec.size() != 2 * B || obs_res.size() != 2) begin
            n_fail++; $display("FAIL proto_unaffected: beats %0d results %0d expected %0d 2", obs_vec.size(), obs_res.size(), 2 * B);
        end
        drive_job(0, 0, 0, 0, 0, 0, 0, 0, '0);
        n_checks++;
        if (err_at_start !== 1'b0 || err_at_end !== 1'b0) begin
            n_fail++; $display("FAIL proto_err_clear: start %b end %b expected 0 0", err_at_start, err_at_end);
        end
    endtask

    task automatic test_reset_midjob();
        int beats = 0, guard = 0;
        start = 1'b1; job_len = JW'(1);
        @(posedge clk); #1;
        start = 1'b0;
        while (beats < 2 && guard < 100) begin
            wgt_ack = wgt_req; act_valid = 1'b1; rand_act();
            if (act_valid && act_ready) beats++;
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (beats != 2 || act_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_reach_feed: beats %0d ready %b expected 2 1", beats, act_ready);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; wgt_ack = 1'b0; act_valid = 1'b0;
        n_checks++;
        if ({busy, done, wgt_req, wgt_hold, act_ready, pe_flush, pe_Abin_vld, res_valid, res_last, err} !== 10'b0 || pe_Abin_vec !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: got %b expected 0", {busy, done, wgt_req, wgt_hold, act_ready, pe_flush, pe_Abin_vld, res_valid, res_last, err});
        end
        drive_job(1, 1, 0, 1, 0, 0, 0, 0, '0);
        n_checks++;
        if (timed_out || n_done != 1 || obs_res.size() != 2 || obs_vec.size() != 2 * B) begin
            n_fail++; $display("FAIL rstmid_recover: done %0d results %0d beats %0d expected 1 2 %0d", n_done, obs_res.size(), obs_vec.size(), 2 * B);
        end
        for (int i = 0; i < obs_res.size() && i < exp_res.size(); i++) begin
            n_checks++;
            if (obs_res[i] !== exp_res[i]) begin
                n_fail++; $display("FAIL rstmid_res%0d: got %0h expected %0h", i, obs_res[i], exp_res[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 4; j++) begin
            int len = $urandom_range(0, 4);
            int bad_vec = 0, bad_res = 0;
            drive_job(len, $urandom_range(0, 1), 0, $urandom_range(0, 3), 1, 0, 0, 0, '0);
            for (int i = 0; i < exp_vec.size(); i++)
                if (i >= obs_vec.size() || obs_vec[i] !== exp_vec[i]) bad_vec++;
            for (int i = 0; i < exp_res.size(); i++)
                if (i >= obs_res.size() || obs_res[i] !== exp_res[i] || obs_last[i] !== (i == len)) bad_res++;
            n_checks++;
            if (timed_out || obs_vec.size() != B * (len + 1) || bad_vec != 0 || n_flush != len + 1) begin
                n_fail++; $display("FAIL b2b%0d_beats: beats %0d bad %0d flush %0d expected %0d 0 %0d", j, obs_vec.size(), bad_vec, n_flush, B * (len + 1), len + 1);
            end
            n_checks++;
            if (obs_res.size() != len + 1 || exp_res.size() != len + 1 || bad_res != 0 || n_unstable != 0) begin
                n_fail++; $display("FAIL b2b%0d_results: got %0d bad %0d unstable %0d expected %0d 0 0", j, obs_res.size(), bad_res, n_unstable, len + 1);
            end
            n_checks++;
            if (n_done != 1 || done_busy !== 1'b0 || n_flush_full != 0 || err_at_end !== 1'b0) begin
                n_fail++; $display("FAIL b2b%0d_done: done %0d busy %b flush_full %0d err %b expected 1 0 0 0", j, n_done, done_busy, n_flush_full, err_at_end);
            end
        end
    endtask

`ifdef BITLET_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int beats = 0, guard = 0, wait_cyc = 0;
        bit got_done = 0, busy_at_done = 1;
        start = 1'b1; job_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        while (beats < B && guard < 200) begin
            wgt_ack = wgt_req; act_valid = 1'b1; rand_act();
            if (act_valid && act_ready) beats++;
            @(posedge clk); #1;
            guard++;
        end
        wgt_ack = 1'b0; act_valid = 1'b0;
        while (!got_done && wait_cyc < 600) begin
            if (done) begin
                got_done = 1; busy_at_done = busy;
            end else begin
                @(posedge clk); #1;
                wait_cyc++;
            end
        end
        n_checks++;
        if (!got_done || wait_cyc < TIMEOUT || wait_cyc > TIMEOUT + 3) begin
            n_fail++; $display("FAIL timeout_done: done %b after %0d cycles expected 1 near %0d", got_done, wait_cyc, TIMEOUT);
        end
        n_checks++;
        if (err !== 1'b1 || busy_at_done !== 1'b0) begin
            n_fail++; $display("FAIL timeout_state: err %b busy %b expected 1 0", err, busy_at_done);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_multi();
        test_backpressure();
        test_protocol();
        test_reset_midjob();
        test_back_to_back();
`ifdef BITLET_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
